// File: rtl/awg_pkg.sv
// Shared types and constants for the PMOD arbitrary-waveform burst sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: waveform shape and FSM state enums, power-on configuration
// defaults, the largest supported log2(samples per cycle) and a clamp helper.
package awg_pkg;

  localparam int unsigned PLOG2_MAX = 8;

  typedef enum logic [1:0] {
    SQUARE = 2'd0,
    SAW    = 2'd1,
    TRI    = 2'd2,
    DC     = 2'd3
  } shape_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Configuration loaded by reset: 128-sample square wave at full rate, amplitude 128, continuous.
  localparam shape_e      DEF_SHAPE  = SQUARE;
  localparam logic [3:0]  DEF_PLOG2  = 4'd7;
  localparam logic [7:0]  DEF_AMP    = 8'd128;
  localparam int unsigned DEF_DIV    = 1;
  localparam int unsigned DEF_CYCLES = 0;

  // Limit the requested log2(samples per cycle) to what the phase counter can hold.
  function automatic logic [3:0] clamp_plog2(input logic [3:0] k, input int unsigned kmax);
    logic [3:0] kmax_w;
    kmax_w = 4'(kmax);
    return (k > kmax_w) ? kmax_w : k;
  endfunction

endpackage

// File: rtl/awg_shape_calc.sv
// Maps (shape, phase, log2 period, amplitude) to an 8-bit sample value.
// Latency: combinational; the sequencer registers the result.
// Backpressure: none.
//
// Ports: shape/ph/k/amp in, value out. Products are formed at 16 bits and
// the shifted result is truncated to 8 bits.
module awg_shape_calc import awg_pkg::*; #(
  parameter int unsigned PH_W = 8
) (
  input  shape_e          shape,
  input  logic [PH_W-1:0] ph,
  input  logic [3:0]      k,
  input  logic [7:0]      amp,
  output logic [7:0]      value
);

  logic [15:0] ph_w;
  logic [15:0] amp_w;
  logic [15:0] p_w;
  logic [15:0] half_w;
  logic [15:0] prod_w;

  always_comb begin
    ph_w   = 16'(ph);
    amp_w  = {8'h00, amp};
    p_w    = 16'(1) << k;
    half_w = p_w >> 1;
    prod_w = 16'h0000;
    value  = 8'h00;
    case (shape)
      // A one-sample period has no low half, so it sits at the amplitude.
      SQUARE: value = ((k == 4'd0) || (ph_w < half_w)) ? amp : 8'h00;
      SAW: begin
        prod_w = (ph_w * amp_w) >> k;
        value  = prod_w[7:0];
      end
      TRI: begin
        // The falling half mirrors the rising half about P-1, so sample P-1 returns to 0.
        if (ph_w < half_w) prod_w = ((ph_w << 1) * amp_w) >> k;
        else               prod_w = (((p_w - 16'd1 - ph_w) << 1) * amp_w) >> k;
        value = prod_w[7:0];
      end
      default: value = amp;
    endcase
  end

endmodule

// File: rtl/awg_sequencer.sv
// Burst sequencer: latches a waveform config and plays N cycles (or forever) onto the PMOD sample bus.
// Latency: first sample one cycle after start; each sample held cfg_div cycles.
// Backpressure: cfg_ready only in IDLE (and not in reset); start outside IDLE is ignored; abort always wins.
//
// Ports: ref_clk/rst (sync, active high); cfg_valid/cfg_ready handshake with
// cfg_shape/plog2/amp/div/cycles; start/abort controls; sample + sample_strobe
// to the pins; busy (RUN), done (completion pulse), led (toggles per cycle).
module awg_sequencer #(
  parameter int unsigned DIV_WIDTH = 16,
  parameter int unsigned CYC_WIDTH = 8,
  parameter int unsigned PLOG2_MAX = awg_pkg::PLOG2_MAX
) (
  input  logic                 ref_clk,
  input  logic                 rst,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [1:0]           cfg_shape,
  input  logic [3:0]           cfg_plog2,
  input  logic [7:0]           cfg_amp,
  input  logic [DIV_WIDTH-1:0] cfg_div,
  input  logic [CYC_WIDTH-1:0] cfg_cycles,
  input  logic                 start,
  input  logic                 abort,
  output logic [7:0]           sample,
  output logic                 sample_strobe,
  output logic                 busy,
  output logic                 done,
  output logic                 led
);
  import awg_pkg::*;

  state_e                 state_q,   state_d;
  shape_e                 shape_q,   shape_d;
  logic [3:0]             k_q,       k_d;
  logic [7:0]             amp_q,     amp_d;
  logic [DIV_WIDTH-1:0]   div_q,     div_d;
  logic [CYC_WIDTH-1:0]   cycles_q,  cycles_d;
  logic [DIV_WIDTH-1:0]   div_cnt_q, div_cnt_d;
  logic [PLOG2_MAX-1:0]   ph_q,      ph_d;
  logic [CYC_WIDTH-1:0]   cyc_cnt_q, cyc_cnt_d;
  logic [7:0]             sample_q,  sample_d;
  logic                   strobe_q,  strobe_d;
  logic                   busy_q,    busy_d;
  logic                   done_q,    done_d;
  logic                   led_q,     led_d;

  logic                   cfg_fire;
  shape_e                 eff_shape;
  logic [3:0]             eff_k;
  logic [7:0]             eff_amp;
  logic [PLOG2_MAX:0]     p_full;
  logic [PLOG2_MAX-1:0]   ph_last;
  logic [PLOG2_MAX-1:0]   ph_nxt;
  logic                   ph_wrap;
  logic                   div_last;
  logic [CYC_WIDTH-1:0]   cyc_inc;
  logic [PLOG2_MAX-1:0]   calc_ph;
  logic [7:0]             calc_val;

  // Effective config: a handshake in the same cycle as start must shape the very first sample.
  always_comb begin
    cfg_ready = (state_q == IDLE) && !rst;
    cfg_fire  = cfg_valid && cfg_ready;
    eff_shape = cfg_fire ? shape_e'(cfg_shape) : shape_q;
    eff_k     = cfg_fire ? clamp_plog2(cfg_plog2, PLOG2_MAX) : k_q;
    eff_amp   = cfg_fire ? cfg_amp : amp_q;
    p_full    = (PLOG2_MAX + 1)'(1) << k_q;
    ph_last   = PLOG2_MAX'(p_full - 1);
    ph_wrap   = (ph_q == ph_last);
    ph_nxt    = ph_wrap ? '0 : ph_q + PLOG2_MAX'(1);
    div_last  = (div_cnt_q == div_q - DIV_WIDTH'(1));
    cyc_inc   = cyc_cnt_q + CYC_WIDTH'(1);
    // In IDLE the next sample is always phase 0; in RUN it is the upcoming phase.
    calc_ph   = (state_q == IDLE) ? '0 : ph_nxt;
  end

  awg_shape_calc #(.PH_W(PLOG2_MAX)) u_shape_calc (
    .shape (eff_shape),
    .ph    (calc_ph),
    .k     (eff_k),
    .amp   (eff_amp),
    .value (calc_val)
  );

  always_comb begin
    state_d   = state_q;
    shape_d   = eff_shape;
    k_d       = eff_k;
    amp_d     = eff_amp;
    div_d     = div_q;
    cycles_d  = cycles_q;
    div_cnt_d = div_cnt_q;
    ph_d      = ph_q;
    cyc_cnt_d = cyc_cnt_q;
    sample_d  = sample_q;
    strobe_d  = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    led_d     = led_q;

    if (cfg_fire) begin
      div_d    = (cfg_div == '0) ? DIV_WIDTH'(1) : cfg_div;
      cycles_d = cfg_cycles;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = RUN;
          busy_d    = 1'b1;
          sample_d  = calc_val;
          strobe_d  = 1'b1;
          ph_d      = '0;
          div_cnt_d = '0;
          cyc_cnt_d = '0;
        end
      end
      RUN: begin
        if (div_last) begin
          div_cnt_d = '0;
          ph_d      = ph_nxt;
          sample_d  = calc_val;
          strobe_d  = 1'b1;
          if (ph_wrap) begin
            cyc_cnt_d = cyc_inc;
            led_d     = ~led_q;
            // Finite burst: the just-finished cycle was the last one.
            if ((cycles_q != '0) && (cyc_inc == cycles_q)) begin
              state_d  = DONE;
              busy_d   = 1'b0;
              done_d   = 1'b1;
              sample_d = 8'h00;
              strobe_d = 1'b0;
            end
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_WIDTH'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Abort overrides everything above, including a start in the same cycle.
    if (abort) begin
      state_d   = IDLE;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      sample_d  = 8'h00;
      strobe_d  = 1'b0;
      led_d     = led_q;
      ph_d      = '0;
      div_cnt_d = '0;
      cyc_cnt_d = '0;
    end
  end

  always_ff @(posedge ref_clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shape_q   <= DEF_SHAPE;
      k_q       <= DEF_PLOG2;
      amp_q     <= DEF_AMP;
      div_q     <= DIV_WIDTH'(DEF_DIV);
      cycles_q  <= CYC_WIDTH'(DEF_CYCLES);
      div_cnt_q <= '0;
      ph_q      <= '0;
      cyc_cnt_q <= '0;
      sample_q  <= 8'h00;
      strobe_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      led_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shape_q   <= shape_d;
      k_q       <= k_d;
      amp_q     <= amp_d;
      div_q     <= div_d;
      cycles_q  <= cycles_d;
      div_cnt_q <= div_cnt_d;
      ph_q      <= ph_d;
      cyc_cnt_q <= cyc_cnt_d;
      sample_q  <= sample_d;
      strobe_q  <= strobe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      led_q     <= led_d;
    end
  end

  assign sample        = sample_q;
  assign sample_strobe = strobe_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign led           = led_q;

endmodule

// File: tb/tb_awg_sequencer.sv
// Directed bench for awg_sequencer: each task drives one scenario and checks inline.
// Inputs change 1 ns after a rising edge; outputs are sampled at the same point.
module tb_awg_sequencer;

  logic        ref_clk = 1'b0;
  logic        rst;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  cfg_shape;
  logic [3:0]  cfg_plog2;
  logic [7:0]  cfg_amp;
  logic [15:0] cfg_div;
  logic [7:0]  cfg_cycles;
  logic        start;
  logic        abort;
  logic [7:0]  sample;
  logic        sample_strobe;
  logic        busy;
  logic        done;
  logic        led;

  int tests = 0;
  int fails = 0;

  always #5 ref_clk = ~ref_clk;

  awg_sequencer dut (
    .ref_clk       (ref_clk),
    .rst           (rst),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .cfg_shape     (cfg_shape),
    .cfg_plog2     (cfg_plog2),
    .cfg_amp       (cfg_amp),
    .cfg_div       (cfg_div),
    .cfg_cycles    (cfg_cycles),
    .start         (start),
    .abort         (abort),
    .sample        (sample),
    .sample_strobe (sample_strobe),
    .busy          (busy),
    .done          (done),
    .led           (led)
  );

  task automatic tick();
    @(posedge ref_clk);
    #1;
  endtask

  task automatic send_cfg(input logic [1:0] sh, input logic [3:0] pl, input logic [7:0] a,
                          input logic [15:0] d, input logic [7:0] n);
    cfg_shape = sh; cfg_plog2 = pl; cfg_amp = a; cfg_div = d; cfg_cycles = n;
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    tests++; if (cfg_ready !== 1'b0) begin fails++; $display("FAIL rst_cfg_ready got %b exp 0", cfg_ready); end
    tests++; if (sample !== 8'd0) begin fails++; $display("FAIL rst_sample got %0d exp 0", sample); end
    tests++; if (sample_strobe !== 1'b0) begin fails++; $display("FAIL rst_strobe got %b exp 0", sample_strobe); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy got %b exp 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL rst_done got %b exp 0", done); end
    tests++; if (led !== 1'b0) begin fails++; $display("FAIL rst_led got %b exp 0", led); end
    rst = 1'b0;
    #1;
    tests++; if (cfg_ready !== 1'b1) begin fails++; $display("FAIL rst_release_ready got %b exp 1", cfg_ready); end
  endtask

  // Reset defaults: square, P=128, A=128, D=1, continuous.
  task automatic test_default_square();
    logic       led0;
    logic [7:0] exp_s;
    logic       exp_l;
    led0 = led;
    pulse_start();
    for (int j = 0; j < 256; j++) begin
      exp_s = ((j % 128) < 64) ? 8'd128 : 8'd0;
      exp_l = (j < 128) ? led0 : ~led0;
      tests++; if (sample !== exp_s) begin fails++; $display("FAIL sq_sample j=%0d got %0d exp %0d", j, sample, exp_s); end
      tests++; if (led !== exp_l) begin fails++; $display("FAIL sq_led j=%0d got %b exp %b", j, led, exp_l); end
      tests++; if (done !== 1'b0) begin fails++; $display("FAIL sq_done j=%0d got %b exp 0", j, done); end
      if (j == 0) begin
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL sq_busy got %b exp 1", busy); end
        tests++; if (sample_strobe !== 1'b1) begin fails++; $display("FAIL sq_strobe got %b exp 1", sample_strobe); end
        tests++; if (cfg_ready !== 1'b0) begin fails++; $display("FAIL sq_cfg_ready got %b exp 0", cfg_ready); end
      end
      tick();
    end
    tests++; if (led !== led0) begin fails++; $display("FAIL sq_led_2nd_wrap got %b exp %b", led, led0); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL sq_continuous_busy got %b exp 1", busy); end
    pulse_abort();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL sq_abort_busy got %b exp 0", busy); end
  endtask

  task automatic test_saw_burst();
    logic [7:0] saw_exp [4];
    logic       led0;
    logic       exp_l;
    saw_exp = '{8'd0, 8'd50, 8'd100, 8'd150};
    send_cfg(2'd1, 4'd2, 8'd200, 16'd3, 8'd2);
    led0 = led;
    pulse_start();
    for (int j = 0; j < 8; j++) begin
      for (int r = 0; r < 3; r++) begin
        exp_l = (j < 4) ? led0 : ~led0;
        tests++; if (sample !== saw_exp[j % 4]) begin fails++; $display("FAIL saw_sample j=%0d r=%0d got %0d exp %0d", j, r, sample, saw_exp[j % 4]); end
        tests++; if (sample_strobe !== (r == 0)) begin fails++; $display("FAIL saw_strobe j=%0d r=%0d got %b", j, r, sample_strobe); end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL saw_busy j=%0d r=%0d got %b exp 1", j, r, busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL saw_early_done j=%0d r=%0d got %b exp 0", j, r, done); end
        tests++; if (led !== exp_l) begin fails++; $display("FAIL saw_led j=%0d got %b exp %b", j, led, exp_l); end
        tick();
      end
    end
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL saw_done got %b exp 1", done); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL saw_done_busy got %b exp 0", busy); end
    tests++; if (sample !== 8'd0) begin fails++; $display("FAIL saw_done_sample got %0d exp 0", sample); end
    tests++; if (cfg_ready !== 1'b0) begin fails++; $display("FAIL saw_done_ready got %b exp 0", cfg_ready); end
    tests++; if (led !== led0) begin fails++; $display("FAIL saw_done_led got %b exp %b", led, led0); end
    tick();
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL saw_done_pulse_len got %b exp 0", done); end
    tests++; if (cfg_ready !== 1'b1) begin fails++; $display("FAIL saw_idle_ready got %b exp 1", cfg_ready); end
    tests++; if (sample !== 8'd0) begin fails++; $display("FAIL saw_idle_sample got %0d exp 0", sample); end
  endtask

  task automatic test_tri_burst();
    logic [7:0] tri_exp [8];
    logic       led0;
    tri_exp = '{8'd0, 8'd63, 8'd127, 8'd191, 8'd191, 8'd127, 8'd63, 8'd0};
    send_cfg(2'd2, 4'd3, 8'd255, 16'd1, 8'd1);
    led0 = led;
    pulse_start();
    for (int j = 0; j < 8; j++) begin
      tests++; if (sample !== tri_exp[j]) begin fails++; $display("FAIL tri_sample j=%0d got %0d exp %0d", j, sample, tri_exp[j]); end
      tests++; if (sample_strobe !== 1'b1) begin fails++; $display("FAIL tri_strobe j=%0d got %b exp 1", j, sample_strobe); end
      tick();
    end
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL tri_done got %b exp 1", done); end
    tests++; if (led !== ~led0) begin fails++; $display("FAIL tri_led got %b exp %b", led, ~led0); end
    tick();
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL tri_done_after got %b exp 0", done); end
  endtask

  task automatic test_abort();
    send_cfg(2'd1, 4'd4, 8'd160, 16'd2, 8'd0);
    pulse_start();
    for (int i = 0; i < 4; i++) tick();
    tests++; if (sample !== 8'd20) begin fails++; $display("FAIL abort_pre_sample got %0d exp 20", sample); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL abort_pre_busy got %b exp 1", busy); end
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_busy got %b exp 0", busy); end
    tests++; if (sample !== 8'd0) begin fails++; $display("FAIL abort_sample got %0d exp 0", sample); end
    tests++; if (sample_strobe !== 1'b0) begin fails++; $display("FAIL abort_strobe got %b exp 0", sample_strobe); end
    tests++; if (cfg_ready !== 1'b1) begin fails++; $display("FAIL abort_ready got %b exp 1", cfg_ready); end
    for (int i = 0; i < 10; i++) begin
      tests++; if (done !== 1'b0) begin fails++; $display("FAIL abort_no_done i=%0d got %b exp 0", i, done); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_no_restart i=%0d got %b exp 0", i, busy); end
      tick();
    end
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_beats_start got %b exp 0", busy); end
    tests++; if (sample !== 8'd0) begin fails++; $display("FAIL abort_beats_start_sample got %0d exp 0", sample); end
  endtask

  task automatic test_cfg_with_start();
    cfg_shape = 2'd3; cfg_plog2 = 4'd3; cfg_amp = 8'd77; cfg_div = 16'd2; cfg_cycles = 8'd0;
    cfg_valid = 1'b1; start = 1'b1;
    tick();
    cfg_valid = 1'b0; start = 1'b0;
    tests++; if (sample !== 8'd77) begin fails++; $display("FAIL cs_first_sample got %0d exp 77", sample); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL cs_busy got %b exp 1", busy); end
    tests++; if (sample_strobe !== 1'b1) begin fails++; $display("FAIL cs_strobe got %b exp 1", sample_strobe); end
    cfg_shape = 2'd0; cfg_amp = 8'd5; cfg_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tests++; if (cfg_ready !== 1'b0) begin fails++; $display("FAIL cs_run_ready i=%0d got %b exp 0", i, cfg_ready); end
      tests++; if (sample !== 8'd77) begin fails++; $display("FAIL cs_run_sample i=%0d got %0d exp 77", i, sample); end
      tick();
    end
    cfg_valid = 1'b0;
    pulse_abort();
    tests++; if (sample !== 8'd0) begin fails++; $display("FAIL cs_idle_sample got %0d exp 0", sample); end
    pulse_start();
    tests++; if (sample !== 8'd77) begin fails++; $display("FAIL cs_cfg_kept got %0d exp 77", sample); end
    pulse_abort();
  endtask

  task automatic test_clamp();
    logic       led0;
    logic [7:0] exp_s;
    send_cfg(2'd0, 4'd12, 8'd200, 16'd0, 8'd1);
    led0 = led;
    pulse_start();
    for (int j = 0; j < 256; j++) begin
      // start while running must not restart the burst
      if (j == 10) start = 1'b1;
      if (j == 11) start = 1'b0;
      exp_s = (j < 128) ? 8'd200 : 8'd0;
      tests++; if (sample !== exp_s) begin fails++; $display("FAIL clamp_sample j=%0d got %0d exp %0d", j, sample, exp_s); end
      tests++; if (done !== 1'b0) begin fails++; $display("FAIL clamp_early_done j=%0d got %b exp 0", j, done); end
      tick();
    end
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL clamp_done got %b exp 1", done); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL clamp_busy got %b exp 0", busy); end
    tests++; if (led !== ~led0) begin fails++; $display("FAIL clamp_led got %b exp %b", led, ~led0); end
    tick();
  endtask

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; cfg_shape = 2'd0; cfg_plog2 = 4'd0; cfg_amp = 8'd0;
    cfg_div = 16'd0; cfg_cycles = 8'd0; start = 1'b0; abort = 1'b0;
    test_reset();
    test_default_square();
    test_saw_burst();
    test_tri_burst();
    test_abort();
    test_cfg_with_start();
    test_clamp();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
